// File: rtl/dff_pkg.sv
// Shared defaults and parameter legality check for the dff_sync_rst family.
// Optional clock enable is selected with macro DFF_SYNC_RST_CE_EN.
package dff_pkg;

  localparam int DFF_DEFAULT_WIDTH  = 1;
  localparam int DFF_DEFAULT_STAGES = 1;
  localparam int DFF_MAX_WIDTH      = 1024;
  localparam int DFF_MAX_STAGES     = 64;

  // True when width and depth are inside the supported range.
  function automatic bit dff_params_ok(input int width, input int stages);
    return (width >= 1) && (width <= DFF_MAX_WIDTH) &&
           (stages >= 1) && (stages <= DFF_MAX_STAGES);
  endfunction

endpackage

// File: rtl/dff_cell.sv
// Single WIDTH-bit register, synchronous active-low reset to RESET_VAL.
// Ports: clk, RST_N, ce (only with DFF_SYNC_RST_CE_EN), d, q.
module dff_cell
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             RST_N,
`ifdef DFF_SYNC_RST_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over the enable; no reset in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      q <= RESET_VAL;
`ifdef DFF_SYNC_RST_CE_EN
    end else if (ce) begin
`else
    end else begin
`endif
      q <= d;
    end
  end

endmodule

// File: rtl/dff_sync_rst.sv
// D register / delay line of STAGES dff_cell stages, sync active-low reset.
// Ports: clk, RST_N, ce (only with DFF_SYNC_RST_CE_EN), din, dout.
module dff_sync_rst
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
  parameter int               STAGES    = DFF_DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             RST_N,
`ifdef DFF_SYNC_RST_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (!dff_params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("dff_sync_rst: WIDTH or STAGES out of range");
  end

  // chain[0] is din; chain[i+1] is the output of stage i.
  logic [STAGES:0][WIDTH-1:0] chain;

  assign chain[0] = din;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    dff_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk   (clk),
      .RST_N (RST_N),
`ifdef DFF_SYNC_RST_CE_EN
      .ce    (ce),
`endif
      .d     (chain[i]),
      .q     (chain[i+1])
    );
  end

  assign dout = chain[STAGES];

endmodule

// File: tb/tb_dff_sync_rst.sv
// Directed bench: default single-bit DFF and an 8-bit 3-stage delay line.
// Ports exercised: clk, RST_N, ce (with DFF_SYNC_RST_CE_EN), din, dout.
module tb_dff_sync_rst;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       rst_b;
  logic       ce_a;
  logic       ce_b;
  logic [0:0] din_a;
  logic [0:0] dout_a;
  logic [7:0] din_b;
  logic [7:0] dout_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff_sync_rst u_dut_a (
    .clk   (clk),
    .RST_N (rst_a),
`ifdef DFF_SYNC_RST_CE_EN
    .ce    (ce_a),
`endif
    .din   (din_a),
    .dout  (dout_a)
  );

  dff_sync_rst #(
    .WIDTH     (8),
    .STAGES    (3),
    .RESET_VAL (8'hA5)
  ) u_dut_b (
    .clk   (clk),
    .RST_N (rst_b),
`ifdef DFF_SYNC_RST_CE_EN
    .ce    (ce_b),
`endif
    .din   (din_b),
    .dout  (dout_b)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle at the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Delay-line vectors: RST_N, din, expected dout after the edge.
  logic       vb_rst [10] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
  logic [7:0] vb_din [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                              8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
  logic [7:0] vb_exp [10] = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03,
                              8'hA5, 8'hA5, 8'hA5, 8'h07, 8'h08};

  // Single-bit waveform: 3 cycles high, 2 low, repeated.
  logic       va_din [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    ce_a  = 1'b1;
    ce_b  = 1'b1;
    din_a = 1'b1;
    din_b = 8'hFF;

    for (int i = 0; i < 10; i++) begin
      cyc();
      check("rst_a", {7'd0, dout_a}, 8'h00);
      check("rst_b", dout_b, 8'hA5);
    end

    rst_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din_a = va_din[i];
      cyc();
      check("follow_a", {7'd0, dout_a}, {7'd0, va_din[i]});
    end

    din_a = 1'b1;
    cyc();
    check("pre_drop_a", {7'd0, dout_a}, 8'h01);
    #2 rst_a = 1'b0;
    #1 check("drop_between", {7'd0, dout_a}, 8'h01);
    cyc();
    check("drop_edge", {7'd0, dout_a}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("low_hold_a", {7'd0, dout_a}, 8'h00);
    end
    rst_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("high_a", {7'd0, dout_a}, 8'h01);
    end

    for (int i = 0; i < 10; i++) begin
      rst_b = vb_rst[i];
      din_b = vb_din[i];
      cyc();
      check($sformatf("pipe_b%0d", i), dout_b, vb_exp[i]);
    end

`ifdef DFF_SYNC_RST_CE_EN
    // Line b now holds 0A,09,08 (stage0..2); dout=08.
    ce_b = 1'b0;
    ce_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din_a = i[0];
      din_b = 8'h30 + 8'(i);
      cyc();
      check("ce_hold_a", {7'd0, dout_a}, 8'h01);
      check("ce_hold_b", dout_b, 8'h08);
    end
    ce_b = 1'b1;
    din_b = 8'h40;
    cyc();
    check("ce_resume_b", dout_b, 8'h09);
    ce_b  = 1'b0;
    ce_a  = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    cyc();
    check("ce_rst_a", {7'd0, dout_a}, 8'h00);
    check("ce_rst_b", dout_b, 8'hA5);
    rst_a = 1'b1;
    rst_b = 1'b1;
    ce_a  = 1'b1;
    ce_b  = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
